// File: rtl/voice_div_arbiter.sv
// Shared restoring divider for voice channels: arbitrates, divides one bit per cycle, returns quot/rem/id.
// Define VDIV_ROUND_ROBIN_EN for round-robin arbitration; otherwise lowest index wins.
module voice_div_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int DWIDTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_num,
  input  logic [NUM_REQ*DWIDTH-1:0]  req_den,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]           rsp_quot,
  output logic [DWIDTH-1:0]          rsp_rem,
  output logic                       busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, DIV, RESP} state_t;

  state_t state, state_nx;

  logic              any;
  logic              accept;
  logic [IDW-1:0]    gnt;
  logic [WIDTH-1:0]  sel_num;
  logic [DWIDTH-1:0] sel_den;
  logic [WIDTH-1:0]  num_q;
  logic [DWIDTH-1:0] den_q;
  logic [DWIDTH-1:0] rem_q;
  logic [IDW-1:0]    id_q;
  logic [CW-1:0]     cnt;
  logic [DWIDTH:0]   pr;
  logic              ge;
  logic [DWIDTH-1:0] rem_nx;

`ifdef VDIV_ROUND_ROBIN_EN
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] idx;

  // Walk from farthest to nearest so the entry after last_grant wins.
  always_comb begin
    gnt = '0;
    any = 1'b0;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = last_grant + IDW'(k);
      if (req_valid[idx]) begin
        gnt = idx;
        any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      last_grant <= IDW'(NUM_REQ - 1);
    else if (accept)
      last_grant <= gnt;
  end
`else
  always_comb begin
    gnt = '0;
    any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        gnt = IDW'(i);
        any = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    sel_num = '0;
    sel_den = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt == IDW'(i)) begin
        sel_num = req_num[i*WIDTH +: WIDTH];
        sel_den = req_den[i*DWIDTH +: DWIDTH];
      end
    end
  end

  assign accept = (state == IDLE) && any;

  // Partial remainder always ends below den, so DWIDTH bits hold it.
  assign pr     = {rem_q, num_q[WIDTH-1]};
  assign ge     = pr >= {1'b0, den_q};
  assign rem_nx = ge ? DWIDTH'(pr - {1'b0, den_q}) : pr[DWIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (any) state_nx = (sel_den == '0) ? RESP : DIV;
      DIV:  if (cnt == '0) state_nx = RESP;
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt] = 1'b1;
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      num_q    <= '0;
      den_q    <= '0;
      rem_q    <= '0;
      id_q     <= '0;
      cnt      <= '0;
      rsp_id   <= '0;
      rsp_quot <= '0;
      rsp_rem  <= '0;
    end else if (accept) begin
      id_q  <= gnt;
      den_q <= sel_den;
      num_q <= sel_num;
      rem_q <= '0;
      cnt   <= CW'(WIDTH - 1);
      if (sel_den == '0) begin
        rsp_id   <= gnt;
        rsp_quot <= sel_num;
        rsp_rem  <= '0;
      end
    end else if (state == DIV) begin
      num_q <= {num_q[WIDTH-2:0], ge};
      rem_q <= rem_nx;
      cnt   <= cnt - CW'(1);
      if (cnt == '0) begin
        rsp_id   <= id_q;
        rsp_quot <= {num_q[WIDTH-2:0], ge};
        rsp_rem  <= rem_nx;
      end
    end
  end

endmodule

// File: tb/tb_voice_div_arbiter.sv
// Scoreboard bench for voice_div_arbiter: directed requests, monitor pops expected results.
// Expected service orders follow VDIV_ROUND_ROBIN_EN when it is defined.
module tb_voice_div_arbiter;

  localparam int N = 4;
  localparam int W = 16;
  localparam int D = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_num = '0;
  logic [N*D-1:0] req_den = '0;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_quot;
  logic [D-1:0]   rsp_rem;
  logic           busy;

  voice_div_arbiter #(.NUM_REQ(N), .WIDTH(W), .DWIDTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_num(req_num), .req_den(req_den),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_quot(rsp_quot), .rsp_rem(rsp_rem),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int id; int quot; int rem; int lat;} exp_t;
  exp_t sb[$];
  exp_t e;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  bit auto_drop = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: accept bookkeeping, response scoreboard, stall stability.
  logic       pv = 1'b0;
  logic       pr = 1'b0;
  logic [1:0] hid;
  logic [W-1:0] hq;
  logic [D-1:0] hr;
  int acc_cyc = 0;
  int hs_cyc = -100;
  int last_gap = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      if (req_ready != '0) begin
        chk("ready_onehot", int'($onehot(req_ready)), 1);
        chk("ready_without_valid", int'(req_ready & ~req_valid), 0);
        acc_cyc = cyc;
        last_gap = cyc - hs_cyc;
      end
      if (rsp_valid)
        chk("ready_during_resp", int'(req_ready), 0);
      if (rsp_valid && !pv) begin
        if (sb.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_rsp: got id=%0d quot=%0d, expected none", rsp_id, rsp_quot);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", int'(rsp_id), e.id);
          chk("rsp_quot", int'(rsp_quot), e.quot);
          chk("rsp_rem", int'(rsp_rem), e.rem);
          chk("rsp_latency", cyc - acc_cyc, e.lat);
        end
        hid = rsp_id;
        hq = rsp_quot;
        hr = rsp_rem;
      end else if (rsp_valid && pv && !pr) begin
        chk("stall_id_stable", int'(rsp_id), int'(hid));
        chk("stall_quot_stable", int'(rsp_quot), int'(hq));
        chk("stall_rem_stable", int'(rsp_rem), int'(hr));
      end
      if (rsp_valid && rsp_ready) hs_cyc = cyc;
      pv = rsp_valid;
      pr = rsp_ready;
    end
  end

  task automatic tick(output logic [N-1:0] acc);
    @(negedge clk);
    acc = req_ready;
    @(posedge clk);
    #1;
    if (auto_drop) req_valid = req_valid & ~acc;
  endtask

  task automatic set_req(input int i, input int num, input int den);
    req_num[i*W +: W] = W'(num);
    req_den[i*D +: D] = D'(den);
    req_valid[i] = 1'b1;
  endtask

  // Latency in cycles from the req_ready cycle to the first rsp_valid cycle.
  task automatic push(input int id, input int q, input int r, input bit den_zero);
    exp_t x;
    x.id = id;
    x.quot = q;
    x.rem = r;
    x.lat = den_zero ? 1 : W + 1;
    sb.push_back(x);
  endtask

  task automatic drain();
    logic [N-1:0] a;
    int n = 0;
    while ((sb.size() != 0 || busy || req_valid != '0) && n < 300) begin
      tick(a);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errs++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
      sb.delete();
      req_valid = '0;
    end
  endtask

  task automatic check_reset();
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rsp_id", int'(rsp_id), 0);
    chk("rst_rsp_quot", int'(rsp_quot), 0);
    chk("rst_rsp_rem", int'(rsp_rem), 0);
    chk("rst_req_ready", int'(req_ready), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] a;
    int n;
    int cnt;

    rst_n = 1'b0;
    tick(a);
    tick(a);
    check_reset();
    rst_n = 1'b1;

    set_req(0, 9, 3);
    push(0, 3, 0, 1'b0);
    drain();

    set_req(2, 100, 0);
    push(2, 100, 0, 1'b1);
    drain();

    // Re-home the pointer so requester 0 leads.
    rst_n = 1'b0;
    tick(a);
    rst_n = 1'b1;

    set_req(0, 65535, 7);
    set_req(1, 65535, 15);
    set_req(2, 0, 4);
    set_req(3, 1234, 0);
    push(0, 9362, 1, 1'b0);
    push(1, 4369, 0, 1'b0);
    push(2, 0, 0, 1'b0);
    push(3, 1234, 0, 1'b1);
    drain();

    auto_drop = 1'b0;
    set_req(0, 20, 6);
    set_req(1, 7, 8);
    set_req(2, 15, 1);
    set_req(3, 40, 3);
`ifdef VDIV_ROUND_ROBIN_EN
    push(0, 3, 2, 1'b0);
    push(1, 0, 7, 1'b0);
    push(2, 15, 0, 1'b0);
`else
    push(0, 3, 2, 1'b0);
    push(0, 3, 2, 1'b0);
    push(0, 3, 2, 1'b0);
`endif
    n = 0;
    cnt = 0;
    while (cnt < 3 && n < 200) begin
      tick(a);
      if (a != '0) cnt++;
      n++;
    end
    chk("kept_valid_accepts", cnt, 3);
    req_valid = '0;
    auto_drop = 1'b1;
    drain();

    rsp_ready = 1'b0;
    set_req(1, 1000, 9);
    push(1, 111, 1, 1'b0);
    n = 0;
    while (!rsp_valid && n < 100) begin
      tick(a);
      n++;
    end
    chk("stall_reach_resp", int'(rsp_valid), 1);
    set_req(3, 50, 5);
    push(3, 10, 0, 1'b0);
    repeat (5) tick(a);
    chk("stall_still_valid", int'(rsp_valid), 1);
    chk("stall_req3_pending", int'(req_valid[3]), 1);
    rsp_ready = 1'b1;
    drain();
    chk("accept_gap_after_hs", last_gap, 1);

    set_req(0, 500, 7);
    n = 0;
    a = '0;
    while (a == '0 && n < 50) begin
      tick(a);
      n++;
    end
    repeat (7) tick(a);
    chk("mid_div_busy", int'(busy), 1);
    rst_n = 1'b0;
    tick(a);
    check_reset();
    rst_n = 1'b1;

    set_req(0, 500, 7);
    set_req(2, 65535, 2);
    push(0, 71, 3, 1'b0);
    push(2, 32767, 1, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
